qam16_rx_deinterleaver: RTL and testbench
=========================================

# qam16_rx_deinterleaver

Receive-side front end for the 16-QAM transmit chain: hard-decision demaps signed I/Q samples to 4-bit symbols, applies the inverse of the transmit 4-bit interleave permutation, buffers symbols in a small FIFO, and emits the encoder's (v1, v2) bit pairs, two pairs per symbol, toward the convolutional decoder. It sits between the channel/sample source and the Viterbi decoder, in the single fast clock domain.

## Interface
- `LEVEL`, 32: inner constellation amplitude A; symbol levels are ±A and ±3A; decision thresholds are 0 and ±2A.
- `FIFO_DEPTH`, 4: nibble FIFO entries; must be a power of 2 and ≥ 2.
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous clear of FIFO, output FSM and stats.
- `I_in`  in  8  signed in-phase sample.
- `Q_in`  in  8  signed quadrature sample.
- `valid_in`  in  1  sample valid.
- `ready_in`  out  1  block can accept a sample this cycle.
- `v1`  out  1  first bit of the decoded pair.
- `v2`  out  1  second bit of the decoded pair.
- `valid_out`  out  1  v1/v2 valid.
- `out_ready`  in  1  downstream accepts the pair.
- `sym_count`  out  16  accepted-symbol count (see Configuration).

## Operation
- Demap, combinational, one axis at a time. Sign-extend to 9 bits; magnitude |x| is computed in 9 bits, so -128 gives 128.
  - I axis: b3 = (I_in ≥ 0); b2 = (|I_in| < 2·LEVEL).
  - Q axis: b1 = (Q_in ≥ 0); b0 = (|Q_in| < 2·LEVEL).
- Deinterleave: serial order is s0=b1, s1=b3, s2=b0, s3=b2. The stored nibble is {s3,s2,s1,s0}.
- Accept: a sample is accepted when valid_in && ready_in. The deinterleaved nibble is written to the FIFO on that edge.
- ready_in = !fifo_full. ready_in does not depend on valid_in or out_ready.
- Output FSM has three states, encoded in the shared package:
  - EMPTY: valid_out=0. If the FIFO is non-empty, pop into the output register and go to PAIR0.
  - PAIR0: present v1=s0, v2=s1. On out_ready go to PAIR1.
  - PAIR1: present v1=s2, v2=s3. On out_ready, pop again if the FIFO is non-empty and go to PAIR0; otherwise go to EMPTY.
- valid_out is 1 in PAIR0 and PAIR1. v1/v2 hold stable while valid_out && !out_ready.
- A simultaneous FIFO push and pop in one cycle is legal. Occupancy is unchanged and data order is preserved.
- flush has priority over everything. A sample presented during flush is dropped and not counted. The next state is EMPTY with an empty FIFO.

## Timing
- Reset values (reset_n low): FIFO empty, FSM EMPTY, ready_in=1, valid_out=0, v1=v2=0, sym_count=0.
- Latency:
  - Sample accepted at edge N → pair0 valid after edge N+1, when the FIFO was empty and the FSM was in EMPTY.
  - pair1 follows on the edge after pair0 is taken.
- Throughput: one symbol per 2 cycles with out_ready held high. Back-to-back symbols produce a continuous valid_out with no bubble.
- Full: ready_in=0 when FIFO_DEPTH entries are stored. The output register holds one more symbol, so up to FIFO_DEPTH+1 symbols are in flight.
- Pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally. full/empty come from the MSB comparison.
- Reset asserted mid-symbol discards the partial pair with no further output.

## Configuration
- `QAM16_RX_STATS_EN` defined: sym_count increments on every accepted sample and saturates at 16'hFFFF. flush clears it.
- `QAM16_RX_STATS_EN` undefined: no counter logic; sym_count is tied to 0.

## Structure
- Shared package `qam16_rx_pkg` holds:
  - the FSM state enum (EMPTY, PAIR0, PAIR1);
  - the constellation-level constant;
  - the deinterleave bit-index constants.
- Sub-module `qam16_rx_fifo` is a parameterized synchronous FIFO, 4-bit wide, with push, pop, full and empty. It uses the same clk and reset_n.
- Demap and deinterleave are combinational logic in the top.

## Test plan
- Reset with valid_in=0: ready_in=1, valid_out=0, sym_count=0.
- I=96, Q=-96, out_ready=1 → pairs (v1,v2) = (0,1) then (0,0). sym_count=1 with STATS_EN.
- I=32, Q=32 then I=-32, Q=-96 back-to-back → (1,1),(1,1),(0,0),(0,1) on consecutive cycles with no valid_out gap.
- Boundaries I=64, Q=0 and I=-128, Q=-65:
  - nibble for (64, 0): b3..b0 = 1,0,1,1.
  - nibble for (-128, -65): b3..b0 = 0,0,0,0.
- out_ready=0 with 6 samples offered (FIFO_DEPTH=4):
  - 5 are accepted, then ready_in=0.
  - the first pair is held stable.
  - release out_ready → 10 pairs drain in order.
- flush asserted with 3 symbols buffered and valid_in=1 → next cycle valid_out=0, FIFO empty, the flush-cycle sample is absent from the output, sym_count=0.

Source files
------------

// File: rtl/qam16_rx_pkg.sv
// ============================================================================
// Module      : qam16_rx_pkg
// Description : Shared types and constants for the 16-QAM receive deinterleaver.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package qam16_rx_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_PAIR0 = 2'd1,
        ST_PAIR1 = 2'd2
    } state_t;

    localparam int QAM16_LEVEL = 32;

    // Position of each serial bit s0..s3 within the demapped word {b3,b2,b1,b0}
    localparam int S0_IDX = 1;
    localparam int S1_IDX = 3;
    localparam int S2_IDX = 0;
    localparam int S3_IDX = 2;

    function automatic logic [3:0] deinterleave(input logic [3:0] b);
        return {b[S3_IDX], b[S2_IDX], b[S1_IDX], b[S0_IDX]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/qam16_rx_fifo.sv
// ============================================================================
// Module      : qam16_rx_fifo
// Description : Synchronous FIFO with extra-MSB pointers for full/empty detection.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module qam16_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (push && !clear) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

    // Same index with differing wrap bits means the writer has lapped the reader
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

endmodule

`default_nettype wire

// File: rtl/qam16_rx_deinterleaver.sv
// ============================================================================
// Module      : qam16_rx_deinterleaver
// Description : 16-QAM hard demap, inverse interleave, FIFO, (v1,v2) pair output.
//               Optional symbol counter enabled by QAM16_RX_STATS_EN.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module qam16_rx_deinterleaver
    import qam16_rx_pkg::*;
#(
    parameter int LEVEL      = QAM16_LEVEL,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        flush,
    input  logic [7:0]  I_in,
    input  logic [7:0]  Q_in,
    input  logic        valid_in,
    output logic        ready_in,
    output logic        v1,
    output logic        v2,
    output logic        valid_out,
    input  logic        out_ready,
    output logic [15:0] sym_count
);

    localparam logic [8:0] THRESH = 9'(2 * LEVEL);

    logic [8:0] i_ext, q_ext, i_mag, q_mag;
    logic [3:0] demap_bits, nib_in, fifo_rd;
    logic       fifo_full, fifo_empty, push, pop;
    state_t     state_q, state_d;
    logic [3:0] nib_q, nib_d;

    // Nine-bit magnitude so that -128 maps to +128 rather than overflowing
    always_comb begin
        i_ext      = {I_in[7], I_in};
        q_ext      = {Q_in[7], Q_in};
        i_mag      = I_in[7] ? (~i_ext + 9'd1) : i_ext;
        q_mag      = Q_in[7] ? (~q_ext + 9'd1) : q_ext;
        demap_bits = {!I_in[7], (i_mag < THRESH), !Q_in[7], (q_mag < THRESH)};
        nib_in     = deinterleave(demap_bits);
    end

    assign ready_in = !fifo_full;
    assign push     = valid_in && ready_in && !flush;

    qam16_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (4)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (flush),
        .push    (push),
        .wr_data (nib_in),
        .pop     (pop),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_comb begin
        state_d   = state_q;
        nib_d     = nib_q;
        pop       = 1'b0;
        valid_out = 1'b0;
        v1        = 1'b0;
        v2        = 1'b0;
        unique case (state_q)
            ST_EMPTY: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    nib_d   = fifo_rd;
                    state_d = ST_PAIR0;
                end
            end
            ST_PAIR0: begin
                valid_out = 1'b1;
                v1        = nib_q[0];
                v2        = nib_q[1];
                if (out_ready) state_d = ST_PAIR1;
            end
            ST_PAIR1: begin
                valid_out = 1'b1;
                v1        = nib_q[2];
                v2        = nib_q[3];
                if (out_ready) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        nib_d   = fifo_rd;
                        state_d = ST_PAIR0;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        if (flush) begin
            pop     = 1'b0;
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_EMPTY;
            nib_q   <= '0;
        end else begin
            state_q <= state_d;
            nib_q   <= nib_d;
        end
    end

`ifdef QAM16_RX_STATS_EN
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (flush)                         cnt_d = '0;
        else if (push && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    assign sym_count = cnt_q;
`else
    assign sym_count = 16'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_qam16_rx_deinterleaver.sv
// ============================================================================
// Module      : tb_qam16_rx_deinterleaver
// Description : Directed self-checking bench for qam16_rx_deinterleaver.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_qam16_rx_deinterleaver;

`ifdef QAM16_RX_STATS_EN
    localparam bit STATS_EN = 1'b1;
`else
    localparam bit STATS_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset_n;
    logic              flush;
    logic signed [7:0] I_in;
    logic signed [7:0] Q_in;
    logic              valid_in;
    logic              ready_in;
    logic              v1;
    logic              v2;
    logic              valid_out;
    logic              out_ready;
    logic [15:0]       sym_count;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_cnt  = 0;

    always #5 clk = ~clk;

    qam16_rx_deinterleaver #(
        .LEVEL      (32),
        .FIFO_DEPTH (4)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .I_in      (I_in),
        .Q_in      (Q_in),
        .valid_in  (valid_in),
        .ready_in  (ready_in),
        .v1        (v1),
        .v2        (v2),
        .valid_out (valid_out),
        .out_ready (out_ready),
        .sym_count (sym_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; flush = 1'b0; valid_in = 1'b0; out_ready = 1'b0;
        I_in = 8'sd0; Q_in = 8'sd0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (ready_in !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", ready_in); end
        n_checks++;
        if (valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid_out: got %b expected 0", valid_out); end
        n_checks++;
        if ({v1, v2} !== 2'b00) begin n_fail++; $display("FAIL reset_pair: got %b expected 00", {v1, v2}); end
        n_checks++;
        if (sym_count !== 16'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", sym_count); end
        reset_n = 1'b1;
        step();
        exp_cnt = 0;
    endtask

    task automatic test_single();
        I_in = 8'sd96; Q_in = -8'sd96; valid_in = 1'b1; out_ready = 1'b1;
        step();
        exp_cnt++;
        valid_in = 1'b0;
        n_checks++;
        if (valid_out !== 1'b0) begin n_fail++; $display("FAIL single_latency: got valid_out %b expected 0", valid_out); end
        step();
        n_checks++;
        if ({valid_out, v1, v2} !== 3'b101) begin n_fail++; $display("FAIL single_pair0: got %b expected 101", {valid_out, v1, v2}); end
        n_checks++;
        if (sym_count !== (STATS_EN ? 16'(exp_cnt) : 16'd0))
            begin n_fail++; $display("FAIL single_count: got %0d expected %0d", sym_count, STATS_EN ? exp_cnt : 0); end
        step();
        n_checks++;
        if ({valid_out, v1, v2} !== 3'b100) begin n_fail++; $display("FAIL single_pair1: got %b expected 100", {valid_out, v1, v2}); end
        step();
        n_checks++;
        if (valid_out !== 1'b0) begin n_fail++; $display("FAIL single_idle: got valid_out %b expected 0", valid_out); end
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_p [4];
        exp_p[0] = 2'b11; exp_p[1] = 2'b11; exp_p[2] = 2'b00; exp_p[3] = 2'b01;
        out_ready = 1'b1;
        I_in = 8'sd32;  Q_in = 8'sd32;  valid_in = 1'b1;
        step();
        I_in = -8'sd32; Q_in = -8'sd96;
        step();
        valid_in = 1'b0;
        exp_cnt += 2;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if ({valid_out, v1, v2} !== {1'b1, exp_p[k]})
                begin n_fail++; $display("FAIL b2b_pair%0d: got %b expected %b", k, {valid_out, v1, v2}, {1'b1, exp_p[k]}); end
            step();
        end
        n_checks++;
        if (valid_out !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got valid_out %b expected 0", valid_out); end
    endtask

    task automatic test_boundary();
        logic [1:0] exp_p [4];
        exp_p[0] = 2'b11; exp_p[1] = 2'b10; exp_p[2] = 2'b00; exp_p[3] = 2'b00;
        out_ready = 1'b1;
        I_in = 8'sd64;   Q_in = 8'sd0;   valid_in = 1'b1;
        step();
        I_in = -8'sd128; Q_in = -8'sd65;
        step();
        valid_in = 1'b0;
        exp_cnt += 2;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if ({valid_out, v1, v2} !== {1'b1, exp_p[k]})
                begin n_fail++; $display("FAIL boundary_pair%0d: got %b expected %b", k, {valid_out, v1, v2}, {1'b1, exp_p[k]}); end
            step();
        end
        n_checks++;
        if (sym_count !== (STATS_EN ? 16'(exp_cnt) : 16'd0))
            begin n_fail++; $display("FAIL boundary_count: got %0d expected %0d", sym_count, STATS_EN ? exp_cnt : 0); end
    endtask

    task automatic test_full();
        logic signed [7:0] si [6];
        logic signed [7:0] sq [6];
        logic [1:0]        exp_p [10];
        int                accepted;
        si[0] = 8'sd96;   sq[0] = -8'sd96;
        si[1] = 8'sd32;   sq[1] = 8'sd32;
        si[2] = -8'sd32;  sq[2] = -8'sd96;
        si[3] = 8'sd64;   sq[3] = 8'sd0;
        si[4] = -8'sd96;  sq[4] = 8'sd96;
        si[5] = -8'sd128; sq[5] = -8'sd65;
        exp_p[0] = 2'b01; exp_p[1] = 2'b00; exp_p[2] = 2'b11; exp_p[3] = 2'b11;
        exp_p[4] = 2'b00; exp_p[5] = 2'b01; exp_p[6] = 2'b11; exp_p[7] = 2'b10;
        exp_p[8] = 2'b10; exp_p[9] = 2'b00;
        accepted  = 0;
        out_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            I_in = si[k]; Q_in = sq[k]; valid_in = 1'b1;
            if (ready_in === 1'b1) accepted++;
            if (k >= 2) begin
                n_checks++;
                if ({valid_out, v1, v2} !== 3'b101)
                    begin n_fail++; $display("FAIL full_hold%0d: got %b expected 101", k, {valid_out, v1, v2}); end
            end
            step();
        end
        valid_in = 1'b0;
        n_checks++;
        if (accepted != 5) begin n_fail++; $display("FAIL full_accepted: got %0d expected 5", accepted); end
        n_checks++;
        if (ready_in !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b expected 0", ready_in); end
        exp_cnt += 5;
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            n_checks++;
            if ({valid_out, v1, v2} !== {1'b1, exp_p[k]})
                begin n_fail++; $display("FAIL drain_pair%0d: got %b expected %b", k, {valid_out, v1, v2}, {1'b1, exp_p[k]}); end
            step();
        end
        n_checks++;
        if (valid_out !== 1'b0) begin n_fail++; $display("FAIL drain_idle: got valid_out %b expected 0", valid_out); end
        n_checks++;
        if (sym_count !== (STATS_EN ? 16'(exp_cnt) : 16'd0))
            begin n_fail++; $display("FAIL full_count: got %0d expected %0d", sym_count, STATS_EN ? exp_cnt : 0); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            I_in = 8'sd32; Q_in = 8'sd32; valid_in = 1'b1;
            step();
        end
        flush = 1'b1; I_in = -8'sd96; Q_in = 8'sd96; valid_in = 1'b1;
        step();
        flush = 1'b0; valid_in = 1'b0;
        exp_cnt = 0;
        n_checks++;
        if ({valid_out, v1, v2} !== 3'b000) begin n_fail++; $display("FAIL flush_out: got %b expected 000", {valid_out, v1, v2}); end
        n_checks++;
        if (ready_in !== 1'b1) begin n_fail++; $display("FAIL flush_ready: got %b expected 1", ready_in); end
        n_checks++;
        if (sym_count !== 16'd0) begin n_fail++; $display("FAIL flush_count: got %0d expected 0", sym_count); end
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            n_checks++;
            if (valid_out !== 1'b0) begin n_fail++; $display("FAIL flush_quiet%0d: got valid_out %b expected 0", k, valid_out); end
        end
        I_in = 8'sd96; Q_in = -8'sd96; valid_in = 1'b1;
        step();
        valid_in = 1'b0;
        exp_cnt = 1;
        step();
        n_checks++;
        if ({valid_out, v1, v2} !== 3'b101) begin n_fail++; $display("FAIL flush_next_pair0: got %b expected 101", {valid_out, v1, v2}); end
        step();
        n_checks++;
        if ({valid_out, v1, v2} !== 3'b100) begin n_fail++; $display("FAIL flush_next_pair1: got %b expected 100", {valid_out, v1, v2}); end
        step();
        n_checks++;
        if (sym_count !== (STATS_EN ? 16'(exp_cnt) : 16'd0))
            begin n_fail++; $display("FAIL flush_next_count: got %0d expected %0d", sym_count, STATS_EN ? exp_cnt : 0); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        I_in = 8'sd96; Q_in = -8'sd96; valid_in = 1'b1;
        step();
        valid_in = 1'b0;
        step();
        n_checks++;
        if (valid_out !== 1'b1) begin n_fail++; $display("FAIL rstmid_pair0: got valid_out %b expected 1", valid_out); end
        #1;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (valid_out !== 1'b0) begin n_fail++; $display("FAIL rstmid_async: got valid_out %b expected 0", valid_out); end
        step();
        reset_n = 1'b1;
        exp_cnt = 0;
        for (int k = 0; k < 2; k++) begin
            step();
            n_checks++;
            if (valid_out !== 1'b0) begin n_fail++; $display("FAIL rstmid_quiet%0d: got valid_out %b expected 0", k, valid_out); end
        end
        n_checks++;
        if (sym_count !== 16'd0) begin n_fail++; $display("FAIL rstmid_count: got %0d expected 0", sym_count); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_boundary();
        test_full();
        test_flush();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
